// File: rtl/fc_ibuf.sv
// Input buffer for a fully-connected CIM layer: collects one input vector from the
// upstream unit, then replays it to the crossbar tiles as LSB-first bit-planes.

module fc_ibuf_lane #(
  parameter int DW = 8,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW-1:0] d,
  input  logic [BW-1:0] sel,
  output logic          plane_bit
);
  logic [DW-1:0] q;
  logic [DW-1:0] sh;

  // Element storage has no reset; contents are meaningless until rewritten.
  always_ff @(posedge clk)
    if (we) q <= d;

  assign sh        = q >> sel;
  assign plane_bit = sh[0];
endmodule

module fc_ibuf #(
  parameter int input_size    = 512,
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_we,
  input  logic [datatype_size-1:0]                    i_data,
  input  logic                                        i_cim_busy,
  output logic                                        o_busy,
  output logic                                        o_cim_valid,
  output logic [v_cim_tiles-1:0][xbar_size-1:0]       o_cim_data,
  output logic [((datatype_size > 1) ? $clog2(datatype_size) : 1)-1:0] o_bit_idx,
  output logic                                        o_cim_start,
  output logic                                        o_overflow
);
  localparam int PW   = (input_size > 1) ? $clog2(input_size) : 1;
  localparam int BW   = (datatype_size > 1) ? $clog2(datatype_size) : 1;
  localparam int ROWS = v_cim_tiles * xbar_size;

  typedef enum logic [1:0] {
    s_ibuf_fill,
    s_ibuf_full,
    s_ibuf_stream,
    s_ibuf_start
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] wr_ptr, wr_ptr_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic          wr_en;
  logic [ROWS-1:0] plane;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= s_ibuf_fill;
      wr_ptr     <= '0;
      bit_cnt    <= '0;
      o_overflow <= 1'b0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_ptr_nx;
      bit_cnt <= bit_cnt_nx;
      if (i_we && o_busy) o_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    bit_cnt_nx  = bit_cnt;
    o_busy      = 1'b1;
    o_cim_valid = 1'b0;
    o_cim_start = 1'b0;
    case (state)
      s_ibuf_fill: begin
        o_busy = 1'b0;
        if (i_we) begin
          if (wr_ptr == PW'(input_size - 1)) begin
            state_nx  = s_ibuf_full;
            wr_ptr_nx = '0;
          end else begin
            wr_ptr_nx = wr_ptr + PW'(1);
          end
        end
      end
      s_ibuf_full: begin
        if (!i_cim_busy) begin
          state_nx   = s_ibuf_stream;
          bit_cnt_nx = '0;
        end
      end
      s_ibuf_stream: begin
        o_cim_valid = 1'b1;
        // No backpressure: once started, every plane goes out on consecutive cycles.
        if (bit_cnt == BW'(datatype_size - 1)) begin
          state_nx   = s_ibuf_start;
          bit_cnt_nx = '0;
        end else begin
          bit_cnt_nx = bit_cnt + BW'(1);
        end
      end
      s_ibuf_start: begin
        o_cim_start = 1'b1;
        state_nx    = s_ibuf_fill;
        wr_ptr_nx   = '0;
      end
      default: state_nx = s_ibuf_fill;
    endcase
  end

  // Reset beats a coincident write so nothing lands in storage during rst.
  assign wr_en     = i_we && !rst && (state == s_ibuf_fill);
  assign o_bit_idx = o_cim_valid ? bit_cnt : '0;

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    if (g < input_size) begin : g_lane
      logic pb;
      fc_ibuf_lane #(.DW(datatype_size), .BW(BW)) u_lane (
        .clk       (clk),
        .we        (wr_en && (wr_ptr == PW'(g))),
        .d         (i_data),
        .sel       (bit_cnt),
        .plane_bit (pb)
      );
      assign plane[g] = pb & o_cim_valid;
    end else begin : g_pad
      assign plane[g] = 1'b0;
    end
  end

  assign o_cim_data = plane;
endmodule

// File: tb/tb_fc_ibuf.sv
// Directed bench for fc_ibuf: expected bit-planes are queued when a frame is written
// and compared as the buffer streams them out.

module tb_fc_ibuf;
  localparam int IS = 5, XS = 4, DS = 4, VT = 2;

  logic              clk = 1'b0;
  logic              rst, i_we, i_cim_busy;
  logic [DS-1:0]     i_data;
  logic              o_busy, o_cim_valid, o_cim_start, o_overflow;
  logic [VT-1:0][XS-1:0] o_cim_data;
  logic [1:0]        o_bit_idx;

  fc_ibuf #(.input_size(IS), .xbar_size(XS), .datatype_size(DS)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_we        (i_we),
    .i_data      (i_data),
    .i_cim_busy  (i_cim_busy),
    .o_busy      (o_busy),
    .o_cim_valid (o_cim_valid),
    .o_cim_data  (o_cim_data),
    .o_bit_idx   (o_bit_idx),
    .o_cim_start (o_cim_start),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       idx;
    logic [VT*XS-1:0] data;
  } plane_t;

  plane_t        sb[$];
  plane_t        mp;
  int            checks = 0, errors = 0, n_start = 0;
  bit            mon_en = 1'b0;
  logic [DS-1:0] frm[IS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VT*XS-1:0] model_plane(input int b);
    logic [VT*XS-1:0] p;
    logic [DS-1:0]    e;
    p = '0;
    for (int i = 0; i < IS; i++) begin
      e    = frm[i];
      p[i] = e[b];
    end
    return p;
  endfunction

  task automatic push_frame;
    for (int b = 0; b < DS; b++) sb.push_back('{2'(b), model_plane(b)});
  endtask

  // Writes frm[] with `gap` idle cycles before each element; optionally one extra write.
  task automatic fill(input int gap, input bit extra);
    for (int i = 0; i < IS; i++) begin
      for (int g = 0; g < gap; g++) begin
        i_we = 1'b0;
        tick;
        chk("busy_gap", o_busy, 0);
      end
      chk("busy_pre_wr", o_busy, 0);
      i_we   = 1'b1;
      i_data = frm[i];
      if (i == IS - 1) push_frame();
      tick;
    end
    chk("busy_after_last", o_busy, 1);
    if (extra) begin
      i_we   = 1'b1;
      i_data = '1;
      tick;
      chk("overflow_set", o_overflow, 1);
    end
    i_we = 1'b0;
  endtask

  task automatic wait_start;
    int s0, k;
    s0 = n_start;
    k  = 0;
    while (!o_cim_start && k < 40) begin
      tick;
      k++;
    end
    chk("start_seen", o_cim_start, 1);
    tick;
    chk("start_once", n_start - s0, 1);
    chk("start_low", o_cim_start, 0);
    chk("busy_after_start", o_busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_cim_start) n_start++;
      if (o_cim_valid) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mp = sb.pop_front();
          chk("plane_data", o_cim_data, mp.data);
          chk("plane_idx", o_bit_idx, mp.idx);
        end
      end else begin
        chk("data_gated", o_cim_data, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, k;
    // 1: reset with a write held
    rst = 1'b1; i_we = 1'b1; i_data = '1; i_cim_busy = 1'b0;
    repeat (3) tick;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_cim_valid, 0);
    chk("rst_start", o_cim_start, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_bit_idx", o_bit_idx, 0);
    chk("rst_data", o_cim_data, 0);
    rst = 1'b0; i_we = 1'b0; mon_en = 1'b1;
    tick;

    // 2: basic frame 1..5
    frm = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    fill(0, 1'b0);
    tick;
    chk("first_plane_valid", o_cim_valid, 1);
    chk("first_plane_idx", o_bit_idx, 0);
    wait_start();
    chk("ovf_clean", o_overflow, 0);

    // 3: CIM busy holds the full buffer
    i_cim_busy = 1'b1;
    frm = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h9};
    fill(0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("hold_busy", o_busy, 1);
      chk("hold_valid", o_cim_valid, 0);
    end
    i_cim_busy = 1'b0;
    tick;
    chk("release_valid", o_cim_valid, 1);
    wait_start();

    // 4: sixth write overflows and is dropped
    frm = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    fill(0, 1'b1);
    chk("ovf_stream_valid", o_cim_valid, 1);
    wait_start();
    chk("ovf_sticky", o_overflow, 1);

    // 5: gapped writes
    frm = '{4'h9, 4'h6, 4'hA, 4'h3, 4'hC};
    fill(2, 1'b0);
    tick;
    chk("gap_valid", o_cim_valid, 1);
    wait_start();
    chk("ovf_sticky2", o_overflow, 1);

    // 6: reset mid-stream, then a clean frame
    frm = '{4'h7, 4'hE, 4'h1, 4'h8, 4'hB};
    fill(0, 1'b0);
    k = 0;
    while (!(o_cim_valid && o_bit_idx == 2'd2) && k < 20) begin
      tick;
      k++;
    end
    chk("reached_bit2", (o_cim_valid && o_bit_idx == 2'd2), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", o_cim_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_start", o_cim_start, 0);
    chk("mid_rst_idx", o_bit_idx, 0);
    chk("mid_rst_ovf", o_overflow, 0);
    s0 = n_start;
    repeat (3) tick;
    chk("no_start_after_rst", n_start - s0, 0);
    frm = '{4'hF, 4'h0, 4'h5, 4'hA, 4'h3};
    fill(0, 1'b0);
    tick;
    chk("post_rst_valid", o_cim_valid, 1);
    wait_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
